// File: rtl/alu_muldiv.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/compare ops plus iterative
// unsigned multiply/divide writing HI/LO, all results registered behind a start/done handshake.
module alu_muldiv #(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alu_ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zero_flag,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_by_zero
);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpSltu  = 4'b1000;
  localparam logic [3:0] OpMultu = 4'b1001;
  localparam logic [3:0] OpDivu  = 4'b1010;
  localparam logic [3:0] OpMfhi  = 4'b1011;
  localparam logic [3:0] OpNor   = 4'b1100;
  localparam logic [3:0] OpMflo  = 4'b1101;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e        state_q;
  logic [W-1:0]  acc_q;   // MUL: upper product half; DIV: partial remainder
  logic [W-1:0]  wrk_q;   // MUL: multiplier / lower product; DIV: dividend / quotient
  logic [W-1:0]  opnd_q;  // MUL: multiplicand; DIV: divisor
  logic [CW-1:0] cnt_q;

  logic [W-1:0] alu_res;
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_acc_d, mul_wrk_d;
  logic [W:0]   div_shift, div_diff;
  logic         div_ge;
  logic [W-1:0] div_acc_d, div_wrk_d;

  always_comb begin
    alu_res = '0;
    case (alu_ctl)
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res = W'($signed(a) < $signed(b));
      OpSltu:  alu_res = W'(a < b);
      OpMfhi:  alu_res = hi;
      OpMflo:  alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the upper half on a set LSB, then shift right.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_d = mul_sum[W:1];
    mul_wrk_d = {mul_sum[0], wrk_q[W-1:1]};
  end

  // Restoring step: bring in the next dividend bit, subtract divisor if it fits.
  always_comb begin
    div_shift = {acc_q, wrk_q[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_acc_d = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
    div_wrk_d = {wrk_q[W-2:0], div_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      wrk_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      result      <= '0;
      zero_flag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            case (alu_ctl)
              OpMultu: begin
                opnd_q  <= a;
                wrk_q   <= b;
                acc_q   <= '0;
                cnt_q   <= CW'(W);
                busy    <= 1'b1;
                state_q <= StMul;
              end
              OpDivu: begin
                if (b == '0) begin
                  hi          <= a;
                  lo          <= '1;
                  result      <= '1;
                  zero_flag   <= 1'b0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                end else begin
                  opnd_q  <= b;
                  wrk_q   <= a;
                  acc_q   <= '0;
                  cnt_q   <= CW'(W);
                  busy    <= 1'b1;
                  state_q <= StDiv;
                end
              end
              default: begin
                result      <= alu_res;
                zero_flag   <= (alu_res == '0);
                div_by_zero <= 1'b0;
                done        <= 1'b1;
              end
            endcase
          end
        end
        StMul: begin
          acc_q <= mul_acc_d;
          wrk_q <= mul_wrk_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            hi          <= mul_acc_d;
            lo          <= mul_wrk_d;
            result      <= mul_wrk_d;
            zero_flag   <= (mul_wrk_d == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StDiv: begin
          acc_q <= div_acc_d;
          wrk_q <= div_wrk_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            hi          <= div_acc_d;
            lo          <= div_wrk_d;
            result      <= div_wrk_d;
            zero_flag   <= (div_wrk_d == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised self-checking bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alu_ctl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] result, hi, lo;
  logic         zero_flag, busy, done, div_by_zero;

  int total = 0;
  int bad = 0;

  logic [W-1:0] m_hi = '0, m_lo = '0;

  alu_muldiv #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctl(alu_ctl), .a(a), .b(b),
    .result(result), .zero_flag(zero_flag), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: expected result/flags/latency from plain arithmetic; updates model HI/LO.
  task automatic model_op(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] res, output logic dbz, output int lat);
    logic [2*W-1:0] p;
    dbz = 1'b0;
    lat = 0;
    case (ctl)
      4'd0:  res = x & y;
      4'd1:  res = x | y;
      4'd2:  res = x + y;
      4'd6:  res = x - y;
      4'd12: res = ~(x | y);
      4'd7:  res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd8:  res = (x < y) ? 1 : 0;
      4'd9: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
        res = m_lo;
        lat = W;
      end
      4'd10: begin
        if (y == 0) begin
          m_hi = x;
          m_lo = {W{1'b1}};
          dbz = 1'b1;
        end else begin
          m_hi = x % y;
          m_lo = x / y;
          lat = W;
        end
        res = m_lo;
      end
      4'd11: res = m_hi;
      4'd13: res = m_lo;
      default: res = '0;
    endcase
  endtask

  // Issue one op starting #1 after an edge; lat = edges after the start edge until done
  // (-1 on timeout), bcnt = samples with busy high before done.
  task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int bcnt);
    alu_ctl = ctl;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 3 * W) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({result, hi, lo, zero_flag, busy, done, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got res=%h hi=%h lo=%h zf=%b busy=%b done=%b dbz=%b want all 0",
               result, hi, lo, zero_flag, busy, done, div_by_zero);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [3:0]   ctl [8] = '{4'd0, 4'd6, 4'd2, 4'd7, 4'd8, 4'd12, 4'd10, 4'd10};
    logic [W-1:0] xa  [8] = '{32'hF0F0_F0F0, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd0, 32'd100, 32'd9};
    logic [W-1:0] xb  [8] = '{32'hFF00_FF00, 32'd5, 32'd1, 32'd1, 32'd1, 32'd0, 32'd7, 32'd0};
    logic [W-1:0] want [8] = '{32'hF000_F000, 32'd0, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF,
                               32'd14, 32'hFFFF_FFFF};
    logic [W-1:0] r;
    logic dbz;
    int lat, bcnt, elat;
    for (int i = 0; i < 8; i++) begin
      model_op(ctl[i], xa[i], xb[i], r, dbz, elat);
      run_op(ctl[i], xa[i], xb[i], lat, bcnt);
      total++;
      if (result !== want[i] || zero_flag !== (want[i] == 0) || lat != elat
          || div_by_zero !== dbz) begin
        bad++;
        $display("FAIL directed_%0d: got res=%h zf=%b lat=%0d dbz=%b want res=%h zf=%b lat=%0d dbz=%b",
                 i, result, zero_flag, lat, div_by_zero, want[i], want[i] == 0, elat, dbz);
      end
      if (ctl[i] == 4'd10) begin
        total++;
        if (hi !== m_hi || lo !== m_lo) begin
          bad++;
          $display("FAIL divu_hilo_%0d: got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, m_hi, m_lo);
        end
      end
    end
  endtask

  task automatic test_multu_back_to_back();
    logic [W-1:0] r;
    logic dbz;
    int lat, bcnt, elat;
    model_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, dbz, elat);
    run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    total++;
    if (lat != W || bcnt != W) begin
      bad++;
      $display("FAIL multu_timing: got lat=%0d busy_cycles=%0d want %0d and %0d", lat, bcnt, W, W);
    end
    total++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || result !== 32'h1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL multu_value: got hi=%h lo=%h res=%h busy=%b want hi=fffffffe lo=00000001 res=1 busy=0",
               hi, lo, result, busy);
    end
    // Issued in the done cycle: must be accepted and read the new HI.
    run_op(4'd11, 32'd0, 32'd0, lat, bcnt);
    total++;
    if (result !== 32'hFFFF_FFFE || lat != 0 || zero_flag !== 1'b0) begin
      bad++;
      $display("FAIL mfhi_b2b: got res=%h lat=%0d zf=%b want res=fffffffe lat=0 zf=0",
               result, lat, zero_flag);
    end
    run_op(4'd13, 32'd0, 32'd0, lat, bcnt);
    total++;
    if (result !== 32'h1 || lat != 0) begin
      bad++;
      $display("FAIL mflo: got res=%h lat=%0d want res=00000001 lat=0", result, lat);
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] r;
    logic dbz;
    int elat, ndone;
    logic [W-1:0] seen;
    model_op(4'd9, 32'd12345, 32'd6789, r, dbz, elat);
    alu_ctl = 4'd9;
    a = 32'd12345;
    b = 32'd6789;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    alu_ctl = 4'd2;
    a = 32'd1;
    b = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    seen = '0;
    for (int i = 0; i < W + 6; i++) begin
      if (done) begin
        ndone++;
        seen = result;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (ndone != 1 || seen !== r || hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL busy_ignore: got dones=%0d res=%h hi=%h lo=%h want dones=1 res=%h hi=%h lo=%h",
               ndone, seen, hi, lo, r, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int ndone, lat, bcnt, elat;
    logic [W-1:0] r;
    logic dbz;
    alu_ctl = 4'd9;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    #1;
    total++;
    if ({result, hi, lo, zero_flag, busy, done, div_by_zero} !== '0) begin
      bad++;
      $display("FAIL reset_mid_mul: got res=%h hi=%h lo=%h zf=%b busy=%b done=%b dbz=%b want all 0",
               result, hi, lo, zero_flag, busy, done, div_by_zero);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done || busy) ndone++;
      @(posedge clk);
      #1;
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL reset_abort: got %0d cycles with done/busy after reset want 0", ndone);
    end
    model_op(4'd2, 32'd2, 32'd3, r, dbz, elat);
    run_op(4'd2, 32'd2, 32'd3, lat, bcnt);
    total++;
    if (result !== r || lat != 0) begin
      bad++;
      $display("FAIL add_after_reset: got res=%h lat=%0d want res=%h lat=0", result, lat, r);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
                             4'd12, 4'd13, 4'd3, 4'd15};
    logic [3:0]   ctl;
    logic [W-1:0] x, y, r;
    logic dbz;
    int lat, bcnt, elat;
    for (int n = 0; n < 60; n++) begin
      ctl = ops[$urandom_range(0, 12)];
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = x;
        2: y = $urandom_range(1, 9);
        default: ;
      endcase
      model_op(ctl, x, y, r, dbz, elat);
      run_op(ctl, x, y, lat, bcnt);
      total++;
      if (result !== r || zero_flag !== (r == 0) || div_by_zero !== dbz || lat != elat
          || hi !== m_hi || lo !== m_lo || bcnt != elat) begin
        bad++;
        $display("FAIL rand_%0d op=%h a=%h b=%h: got res=%h zf=%b dbz=%b lat=%0d busy=%0d hi=%h lo=%h want res=%h zf=%b dbz=%b lat=%0d hi=%h lo=%h",
                 n, ctl, x, y, result, zero_flag, div_by_zero, lat, bcnt, hi, lo,
                 r, r == 0, dbz, elat, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_multu_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
